// File: rtl/y1_match_arbiter_if.sv
// Request/result handshake bundle for the shared match unit.
// master = producers/consumer side, slave = arbiter side.
interface y1_match_arbiter_if;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic        res_match;
  logic [1:0]  res_id;
  logic [15:0] res_data;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_match, res_id, res_data
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_match, res_id, res_data
  );
endinterface

// File: rtl/y1_match_arbiter.sv
// Round-robin arbiter sharing one 16-input minterm detector among four
// requesters. One grant per cycle, registered tagged result, and
// per-requester saturating match counters for status readback.
module y1_match_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  y1_match_arbiter_if.slave bus,
  input  logic [1:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Minterm: w2 & ~(w0&w1) & w3 & ~w4 & w5 & ~w6 & ~w7 & ~w8 & w9 & w10
  //          & ~w11 & ~w12 & ~w13 & w14 & ~w15
  function automatic logic match_fn(input logic [15:0] w);
    return w[2] & ~(w[0] & w[1]) & w[3] & ~w[4] & w[5] & ~w[6] & ~w[7] &
           ~w[8] & w[9] & w[10] & ~w[11] & ~w[12] & ~w[13] & w[14] & ~w[15];
  endfunction

  logic [1:0]       ptr_q, ptr_d;
  logic             res_valid_q, res_valid_d;
  logic             res_match_q, res_match_d;
  logic [1:0]       res_id_q, res_id_d;
  logic [15:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             accept;
  logic             found;
  logic [1:0]       gid;
  logic [1:0]       idx;
  logic [3:0]       grant;
  logic [15:0]      word;
  logic             word_match;

  assign accept = ~res_valid_q | bus.res_ready;

  // Search from ptr upward (mod 4) for the first valid requester.
  always_comb begin
    found = 1'b0;
    gid   = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
    grant = found ? (4'b0001 << gid) : 4'b0000;
  end

  assign word       = bus.req_data[{gid, 4'b0000} +: 16];
  assign word_match = match_fn(word);

  // Grant is only offered when the result slot can take a word; the reset
  // term keeps req_ready low while rst_n is held.
  assign bus.req_ready = (accept && rst_n) ? grant : 4'b0000;

  // Next-state for the result slot, pointer and counters.
  always_comb begin
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_match_d = res_match_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];

    if (accept) begin
      if (found) begin
        res_valid_d = 1'b1;
        res_id_d    = gid;
        res_data_d  = word;
        res_match_d = word_match;
        ptr_d       = gid + 2'd1;
        if (word_match && cnt_q[gid] != CNT_MAX)
          cnt_d[gid] = cnt_q[gid] + CNT_W'(1);
      end else begin
        res_valid_d = 1'b0;
      end
    end

    // Clear overrides any increment from this cycle's grant.
    if (cnt_clr)
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_id_q    <= 2'd0;
      res_data_q  <= 16'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_match = res_match_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign cnt_out       = cnt_q[cnt_sel];

endmodule
